// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes, instruction classes, wb_sel.
// No logic here.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd7
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      CL_ALU, CL_LUI, CL_AUIPC, CL_BR, CL_JAL, CL_JALR, CL_LD, CL_ST, CL_ILL
   } iclass_t;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct3 to instruction-class decoder, used during ID.
// Purely combinational, zero latency; no flow control.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output iclass_t    iclass
);

   always_comb begin
      iclass = CL_ILL;
      case (opcode)
         OPC_LUI:    iclass = CL_LUI;
         OPC_AUIPC:  iclass = CL_AUIPC;
         OPC_JAL:    iclass = CL_JAL;
         OPC_JALR:   iclass = CL_JALR;
         // funct3 010/011 are unassigned branch encodings
         OPC_BRANCH: iclass = (funct3 == 3'b010 || funct3 == 3'b011) ? CL_ILL : CL_BR;
         OPC_LOAD:   iclass = CL_LD;
         OPC_STORE:  iclass = CL_ST;
         OPC_OPIMM:  iclass = CL_ALU;
         OPC_OP:     iclass = CL_ALU;
         default:    iclass = CL_ILL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/HALT); MC_CTRL_PERF_EN adds cycle/instret counters.
// Latency 3/4/5 cycles per instruction with zero-wait memory; mem_req holds until mem_ack, optional timeout to HALT.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 0
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       br_taken,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_ifetch,
   output logic       ir_we,
   output logic       pc_we,
   output logic       npc_en,
   output logic       c_mux3,
   output logic       c_mux4,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic [2:0] state,
   output logic       illegal
`ifdef MC_CTRL_PERF_EN
  ,output logic [31:0] cyc_cnt,
   output logic [31:0] instret_cnt
`endif
);

   localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

   state_t        state_q, state_d;
   iclass_t       cls_q, dec_cls;
   logic          illegal_q;
   logic [WW-1:0] wait_cnt;
   logic          req_phase;
   logic          timeout;

   mc_decode u_decode (
      .opcode (opcode),
      .funct3 (funct3),
      .iclass (dec_cls)
   );

   // Derived from state rather than mem_req to keep the timeout path loop-free.
   assign req_phase = (state_q == ST_IF) || (state_q == ST_MEM);
   assign timeout   = (MEM_WAIT_MAX > 0) && req_phase && !mem_ack &&
                      (wait_cnt == WW'(MEM_WAIT_MAX - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IF;
         cls_q     <= CL_ALU;
         illegal_q <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_ID)
            cls_q <= dec_cls;
         if (state_d == ST_HALT)
            illegal_q <= 1'b1;
         if (req_phase && !mem_ack)
            wait_cnt <= wait_cnt + WW'(1);
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_ifetch = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      npc_en     = 1'b0;
      c_mux3     = 1'b0;
      c_mux4     = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = WB_ALU;
      case (state_q)
         ST_IF: begin
            mem_req    = 1'b1;
            mem_ifetch = 1'b1;
            if (mem_ack) begin
               ir_we   = 1'b1;
               state_d = ST_ID;
            end else if (timeout) begin
               state_d = ST_HALT;
            end
         end
         ST_ID: state_d = (dec_cls == CL_ILL) ? ST_HALT : ST_EX;
         ST_EX: begin
            case (cls_q)
               CL_BR: begin
                  npc_en  = 1'b1;
                  c_mux3  = br_taken;
                  pc_we   = 1'b1;
                  state_d = ST_IF;
               end
               CL_JAL, CL_JALR: begin
                  npc_en  = 1'b1;
                  c_mux3  = (cls_q == CL_JAL);
                  c_mux4  = (cls_q == CL_JALR);
                  pc_we   = 1'b1;
                  rf_we   = 1'b1;
                  wb_sel  = WB_PC4;
                  state_d = ST_IF;
               end
               CL_LD, CL_ST: state_d = ST_MEM;
               default:      state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = (cls_q == CL_ST);
            if (mem_ack) begin
               if (cls_q == CL_ST) begin
                  npc_en  = 1'b1;
                  pc_we   = 1'b1;
                  state_d = ST_IF;
               end else begin
                  state_d = ST_WB;
               end
            end else if (timeout) begin
               state_d = ST_HALT;
            end
         end
         ST_WB: begin
            rf_we   = 1'b1;
            wb_sel  = (cls_q == CL_LD) ? WB_MEM : WB_ALU;
            npc_en  = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_IF;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_HALT;
      endcase
      if (rst) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         mem_ifetch = 1'b0;
         ir_we      = 1'b0;
         pc_we      = 1'b0;
         npc_en     = 1'b0;
         c_mux3     = 1'b0;
         c_mux4     = 1'b0;
         rf_we      = 1'b0;
         wb_sel     = WB_ALU;
      end
   end

   assign state   = rst ? 3'd0 : state_q;
   assign illegal = illegal_q && !rst;

`ifdef MC_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt     <= 32'd0;
         instret_cnt <= 32'd0;
      end else begin
         if (state_q != ST_HALT)
            cyc_cnt <= cyc_cnt + 32'd1;
         if (pc_we)
            instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected-output traces built from the instruction phase rules.
// Zero-latency model; random ack delays exercise the memory handshake.
module tb_mc_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, br_taken, mem_ack;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       mem_req, mem_we, mem_ifetch, ir_we, pc_we, npc_en, c_mux3, c_mux4, rf_we, illegal;
   logic [1:0] wb_sel;
   logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cyc_cnt, instret_cnt, cyc_cnt2, instret_cnt2;
`endif

   logic       rst2, ack2;
   logic [6:0] opcode2 = 7'b0110011;
   logic [2:0] funct3_2 = 3'b000;
   logic       br2 = 1'b0;
   logic       mem_req2, mem_we2, mem_ifetch2, ir_we2, pc_we2, npc_en2, c_mux3_2, c_mux4_2, rf_we2, illegal2;
   logic [1:0] wb_sel2;
   logic [2:0] state2;

   mc_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ifetch(mem_ifetch), .ir_we(ir_we), .pc_we(pc_we),
      .npc_en(npc_en), .c_mux3(c_mux3), .c_mux4(c_mux4), .rf_we(rf_we), .wb_sel(wb_sel),
      .state(state), .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
     ,.cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt)
`endif
   );

   mc_ctrl #(.MEM_WAIT_MAX(2)) dut2 (
      .clk(clk), .rst(rst2), .opcode(opcode2), .funct3(funct3_2), .br_taken(br2), .mem_ack(ack2),
      .mem_req(mem_req2), .mem_we(mem_we2), .mem_ifetch(mem_ifetch2), .ir_we(ir_we2), .pc_we(pc_we2),
      .npc_en(npc_en2), .c_mux3(c_mux3_2), .c_mux4(c_mux4_2), .rf_we(rf_we2), .wb_sel(wb_sel2),
      .state(state2), .illegal(illegal2)
`ifdef MC_CTRL_PERF_EN
     ,.cyc_cnt(cyc_cnt2), .instret_cnt(instret_cnt2)
`endif
   );

   typedef struct packed {
      logic       mem_req, mem_we, mem_ifetch, ir_we, pc_we, npc_en, c_mux3, c_mux4, rf_we;
      logic [1:0] wb_sel;
      logic [2:0] state;
      logic       illegal;
   } obs_t;

   typedef struct packed {
      logic ack;
      obs_t exp;
   } step_t;

   localparam int K_ALU = 0, K_LUI = 1, K_AUIPC = 2, K_BR = 3, K_JAL = 4, K_JALR = 5,
                  K_LD = 6, K_ST = 7, K_ILL = 8;

   step_t trace[$];
   int    checks = 0;
   int    errors = 0;
   int    retired = 0;

   function automatic obs_t sample();
      obs_t o;
      o.mem_req = mem_req;   o.mem_we = mem_we;   o.mem_ifetch = mem_ifetch;
      o.ir_we = ir_we;       o.pc_we = pc_we;     o.npc_en = npc_en;
      o.c_mux3 = c_mux3;     o.c_mux4 = c_mux4;   o.rf_we = rf_we;
      o.wb_sel = wb_sel;     o.state = state;     o.illegal = illegal;
      return o;
   endfunction

   function automatic obs_t sample2();
      obs_t o;
      o.mem_req = mem_req2;  o.mem_we = mem_we2;  o.mem_ifetch = mem_ifetch2;
      o.ir_we = ir_we2;      o.pc_we = pc_we2;    o.npc_en = npc_en2;
      o.c_mux3 = c_mux3_2;   o.c_mux4 = c_mux4_2; o.rf_we = rf_we2;
      o.wb_sel = wb_sel2;    o.state = state2;    o.illegal = illegal2;
      return o;
   endfunction

   function automatic obs_t blank(input logic [2:0] st);
      obs_t o;
      o = '0;
      o.state = st;
      return o;
   endfunction

   function automatic obs_t fetch_obs();
      obs_t o;
      o = blank(3'd0);
      o.mem_req = 1'b1;
      o.mem_ifetch = 1'b1;
      return o;
   endfunction

   function automatic int base_latency(input int k);
      if (k == K_BR || k == K_JAL || k == K_JALR) return 3;
      if (k == K_LD) return 5;
      return 4;
   endfunction

   function automatic logic [6:0] opc_of(input int k);
      case (k)
         K_ALU:   return ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
         K_LUI:   return 7'b0110111;
         K_AUIPC: return 7'b0010111;
         K_BR:    return 7'b1100011;
         K_JAL:   return 7'b1101111;
         K_JALR:  return 7'b1100111;
         K_LD:    return 7'b0000011;
         K_ST:    return 7'b0100011;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected per-cycle outputs for one instruction, phase by phase.
   task automatic build_instr(input int k, input logic br, input int d_if, input int d_mem);
      obs_t  e;
      step_t s;
      for (int i = 0; i < d_if; i++) begin
         s.ack = 1'b0; s.exp = fetch_obs(); trace.push_back(s);
      end
      e = fetch_obs(); e.ir_we = 1'b1;
      s.ack = 1'b1; s.exp = e; trace.push_back(s);
      s.ack = 1'($urandom); s.exp = blank(3'd1); trace.push_back(s);
      if (k == K_ILL) begin
         for (int i = 0; i < 2; i++) begin
            e = blank(3'd7); e.illegal = 1'b1;
            s.ack = 1'($urandom); s.exp = e; trace.push_back(s);
         end
         return;
      end
      e = blank(3'd2);
      s.ack = 1'($urandom);
      if (k == K_BR || k == K_JAL || k == K_JALR) begin
         e.npc_en = 1'b1;
         e.pc_we  = 1'b1;
         e.c_mux3 = (k == K_BR) ? br : (k == K_JAL);
         e.c_mux4 = (k == K_JALR);
         if (k != K_BR) begin
            e.rf_we  = 1'b1;
            e.wb_sel = 2'b10;
         end
         s.exp = e; trace.push_back(s);
         return;
      end
      s.exp = e; trace.push_back(s);
      if (k == K_LD || k == K_ST) begin
         e = blank(3'd3); e.mem_req = 1'b1; e.mem_we = (k == K_ST);
         for (int i = 0; i < d_mem; i++) begin
            s.ack = 1'b0; s.exp = e; trace.push_back(s);
         end
         if (k == K_ST) begin
            e.npc_en = 1'b1; e.pc_we = 1'b1;
         end
         s.ack = 1'b1; s.exp = e; trace.push_back(s);
         if (k == K_ST) return;
      end
      e = blank(3'd4);
      e.rf_we = 1'b1; e.npc_en = 1'b1; e.pc_we = 1'b1;
      e.wb_sel = (k == K_LD) ? 2'b01 : 2'b00;
      s.ack = 1'($urandom); s.exp = e; trace.push_back(s);
   endtask

   task automatic run_trace(input string name, input int exp_pcw, output int lat);
      int    n, pcw, rfw;
      step_t s;
      obs_t  o;
      n = trace.size(); pcw = 0; rfw = 0; lat = 0;
      for (int i = 0; i < n; i++) begin
         s = trace.pop_front();
         mem_ack = s.ack;
         @(negedge clk);
         o = sample();
         checks++;
         if (o !== s.exp) begin
            errors++;
            $display("FAIL %s cycle %0d: outputs %b, expected %b", name, i, o, s.exp);
         end
         if (o.pc_we === 1'b1) begin
            pcw++;
            if (lat == 0) lat = i + 1;
         end
         if (o.rf_we === 1'b1) rfw++;
         @(posedge clk); #1;
      end
      checks++;
      if (pcw != exp_pcw) begin
         errors++;
         $display("FAIL %s pc_we count: got %0d, expected %0d", name, pcw, exp_pcw);
      end
      checks++;
      if (rfw > 1) begin
         errors++;
         $display("FAIL %s rf_we count: got %0d, expected at most 1", name, rfw);
      end
   endtask

   task automatic do_instr(input string name, input int k, input logic [6:0] opc, input logic [2:0] f3,
                           input logic br, input int d_if, input int d_mem);
      int lat, exp_lat;
      opcode = opc; funct3 = f3; br_taken = br;
      build_instr(k, br, d_if, d_mem);
      run_trace(name, (k == K_ILL) ? 0 : 1, lat);
      if (k != K_ILL) begin
         exp_lat = base_latency(k) + d_if + ((k == K_LD || k == K_ST) ? d_mem : 0);
         checks++;
         if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
         end
         retired++;
      end
   endtask

   task automatic do_reset(input string name, input int ncyc);
      rst = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         mem_ack = 1'($urandom);
         @(negedge clk);
         checks++;
         if (sample() !== blank(3'd0)) begin
            errors++;
            $display("FAIL %s in reset: outputs %b, expected all zero", name, sample());
         end
`ifdef MC_CTRL_PERF_EN
         if (i > 0) begin
            checks++;
            if (cyc_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
               errors++;
               $display("FAIL %s counters: cyc %0d instret %0d, expected 0", name, cyc_cnt, instret_cnt);
            end
         end
`endif
         @(posedge clk); #1;
      end
      rst = 1'b0; mem_ack = 1'b0; retired = 0;
      @(negedge clk);
      checks++;
      if (sample() !== fetch_obs()) begin
         errors++;
         $display("FAIL %s first cycle: outputs %b, expected %b", name, sample(), fetch_obs());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset("reset", 3);
   endtask

   task automatic test_add();
      do_instr("add", K_ALU, 7'b0110011, 3'b000, 1'b0, 0, 0);
   endtask

   task automatic test_branch();
      do_instr("beq_taken", K_BR, 7'b1100011, 3'b000, 1'b1, 0, 0);
      do_instr("beq_not_taken", K_BR, 7'b1100011, 3'b000, 1'b0, 0, 0);
   endtask

   task automatic test_jalr();
      do_instr("jalr", K_JALR, 7'b1100111, 3'b000, 1'b0, 0, 0);
   endtask

   task automatic test_load_delay();
      do_instr("lw_delay3", K_LD, 7'b0000011, 3'b010, 1'b0, 0, 3);
   endtask

   task automatic test_illegal();
      do_instr("illegal_opcode", K_ILL, 7'b1111111, 3'b000, 1'b0, 0, 0);
      do_reset("illegal_reset", 1);
      do_instr("illegal_branch_f3", K_ILL, 7'b1100011, 3'($urandom_range(2, 3)), 1'b0, 1, 0);
      do_reset("illegal_reset2", 2);
   endtask

   task automatic test_reset_store();
      int    lat;
      step_t s;
      opcode = 7'b0100011; funct3 = 3'b010; br_taken = 1'b0;
      build_instr(K_ST, 1'b0, 0, 2);
      s = trace.pop_back();
      run_trace("store_pending", 0, lat);
      rst = 1'b1; mem_ack = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, pc_we} !== 3'b000) begin
         errors++;
         $display("FAIL store_reset strobes: req/we/pc_we %b, expected 000", {mem_req, mem_we, pc_we});
      end
      @(posedge clk); #1;
      @(negedge clk);
`ifdef MC_CTRL_PERF_EN
      checks++;
      if (cyc_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
         errors++;
         $display("FAIL store_reset counters: cyc %0d instret %0d, expected 0", cyc_cnt, instret_cnt);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0; mem_ack = 1'b0; retired = 0;
      @(negedge clk);
      checks++;
      if (sample() !== fetch_obs()) begin
         errors++;
         $display("FAIL store_reset restart: outputs %b, expected %b", sample(), fetch_obs());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      int         k;
      logic [2:0] f3;
      for (int n = 0; n < 40; n++) begin
         k  = $urandom_range(K_ALU, K_ST);
         f3 = (k == K_BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom);
         do_instr($sformatf("random_%0d", n), k, opc_of(k), f3, 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end
`ifdef MC_CTRL_PERF_EN
      checks++;
      if (instret_cnt !== 32'(retired)) begin
         errors++;
         $display("FAIL random instret_cnt: got %0d, expected %0d", instret_cnt, retired);
      end
`endif
   endtask

   task automatic test_timeout();
      obs_t e;
      rst2 = 1'b1; ack2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0; ack2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (sample2() !== fetch_obs()) begin
            errors++;
            $display("FAIL timeout wait %0d: outputs %b, expected %b", i, sample2(), fetch_obs());
         end
         @(posedge clk); #1;
      end
      ack2 = 1'b1;
      @(negedge clk);
      e = blank(3'd7); e.illegal = 1'b1;
      checks++;
      if (sample2() !== e) begin
         errors++;
         $display("FAIL timeout halt: outputs %b, expected %b", sample2(), e);
      end
      @(posedge clk); #1;
      rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0; ack2 = 1'b0;
      @(posedge clk); #1;
      ack2 = 1'b1;
      @(posedge clk); #1;
      ack2 = 1'b0;
      @(negedge clk);
      checks++;
      if (sample2() !== blank(3'd1)) begin
         errors++;
         $display("FAIL timeout late ack: outputs %b, expected %b", sample2(), blank(3'd1));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; mem_ack = 1'b0; br_taken = 1'b0; opcode = 7'b0; funct3 = 3'b0;
      rst2 = 1'b1; ack2 = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_add();
      test_branch();
      test_jalr();
      test_load_delay();
      test_illegal();
      test_reset_store();
      test_random();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
